// File: rtl/gate_pair_check_seq.sv
// gate_pair_check_seq
//   Stimulus and compare sequencer for two implementations of the same
//   2-input gate (continuous-assign and procedural). On start it steps the
//   shared input vector through every value, holds each one for HOLD_CYCLES
//   clocks, samples both gate outputs on the last edge of the hold window,
//   and records mismatches.
//
// Parameters
//   HOLD_CYCLES  cycles each vector is held before sampling (>= 1)
//   N_IN         width of the shared input vector (2^N_IN vectors per run)
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   start             run request, honoured only in IDLE
//   y_wire            output of the continuous-assign gate instance
//   y_reg             output of the procedural gate instance
//   stim              shared gate input vector (a = stim[1], b = stim[0])
//   busy              high while vectors are being driven
//   done              one-cycle pulse at end of run
//   pass              last completed run had zero mismatches
//   mismatch_cnt      mismatches in current/last run
//   first_fail_valid  at least one mismatch recorded this run
//   first_fail_vec    stim value of the first mismatch
`timescale 1ns/1ps

module gate_pair_check_seq #(
  parameter int HOLD_CYCLES = 10,
  parameter int N_IN        = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            y_wire,
  input  logic            y_reg,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam int            CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int            MW        = N_IN + 1;
  localparam logic [CW-1:0] LAST_HOLD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [N_IN-1:0]   stim_n;
  logic              busy_n, done_n, pass_n;
  logic [N_IN:0]     mcnt_n;
  logic              ffv_n;
  logic [N_IN-1:0]   ffvec_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      stim             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      mismatch_cnt     <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      stim             <= stim_n;
      busy             <= busy_n;
      done             <= done_n;
      pass             <= pass_n;
      mismatch_cnt     <= mcnt_n;
      first_fail_valid <= ffv_n;
      first_fail_vec   <= ffvec_n;
    end
  end

  // Every output is a flop; this block computes the value each one takes on
  // the coming edge, so the FSM decisions and the registered outputs stay
  // cycle-aligned.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stim_n  = stim;
    busy_n  = busy;
    done_n  = 1'b0;
    pass_n  = pass;
    mcnt_n  = mismatch_cnt;
    ffv_n   = first_fail_valid;
    ffvec_n = first_fail_vec;

    unique case (state)
      IDLE: begin
        stim_n = '0;
        busy_n = 1'b0;
        if (start) begin
          state_n = DRIVE;
          busy_n  = 1'b1;
          cnt_n   = '0;
          mcnt_n  = '0;
          ffv_n   = 1'b0;
          ffvec_n = '0;
          pass_n  = 1'b0;
        end
      end

      DRIVE: begin
        busy_n = 1'b1;
        cnt_n  = cnt + CW'(1);
        if (cnt == LAST_HOLD) begin
          cnt_n = '0;
          if (y_wire != y_reg) begin
            mcnt_n = mismatch_cnt + MW'(1);
            if (!first_fail_valid) begin
              ffv_n   = 1'b1;
              ffvec_n = stim;
            end
          end
          if (stim == '1) begin
            // pass must include a mismatch counted on this final sample.
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            stim_n  = '0;
            pass_n  = (mcnt_n == '0);
          end else begin
            stim_n = stim + N_IN'(1);
          end
        end
      end

      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        stim_n  = '0;
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        stim_n  = '0;
      end
    endcase
  end

endmodule

// File: doc/gate_pair_check_seq.md
# gate_pair_check_seq

Synthesizable stimulus and compare sequencer for a pair of 2-input gate implementations (continuous-assign model and procedural model) that share one input pair. When started, it walks the shared input vector through every combination, holding each for a fixed number of cycles. At the end of each hold it samples both outputs and records mismatches. It sits above the two gate instances and replaces hand-written input stepping with a repeatable on-chip or bench-driven check.

## Interface
- HOLD_CYCLES, 10, cycles each input vector is held before sampling (legal ≥1)
- N_IN, 2, width of the shared input vector; 2^N_IN vectors per run

- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  run request, sampled only in IDLE
- y_wire  input  1  output of the continuous-assign gate instance
- y_reg  input  1  output of the procedural gate instance
- stim  output  N_IN  shared gate input vector; top level maps a=stim[1], b=stim[0]
- busy  output  1  high while vectors are being driven
- done  output  1  one-cycle pulse at end of run
- pass  output  1  high when the last completed run had zero mismatches
- mismatch_cnt  output  N_IN+1  mismatches in current/last run
- first_fail_valid  output  1  at least one mismatch recorded this run
- first_fail_vec  output  N_IN  stim value of first mismatch

## Operation
- Reset is one clock and asynchronous, active-low. While rst_n=0, all outputs are 0, state is IDLE, and the hold counter is 0. This applies at any point, including mid-run. There is no partial-result retention.
- FSM states: IDLE, DRIVE, DONE.
- IDLE: stim=0 and busy=0. If start=1 at an edge, the block moves to DRIVE. On that same edge it clears mismatch_cnt, first_fail_valid, first_fail_vec and pass, sets stim=0, and sets the hold counter to 0.
- DRIVE: busy=1. The hold counter increments every cycle.
  - On the edge where the counter equals HOLD_CYCLES-1, the block compares y_wire != y_reg.
  - On a mismatch, mismatch_cnt increments. If first_fail_valid=0, it also sets first_fail_valid=1 and first_fail_vec=stim.
  - On the same edge, if stim = all-ones, the block moves to DONE. Otherwise stim increments and the counter returns to 0.
- DONE: done=1, busy=0, stim=0. pass is set to (mismatch_cnt==0), accounting for any increment made on the final sample edge. The next edge moves to IDLE unconditionally.
- Results (mismatch_cnt, first_fail_*, pass) hold their values until the next accepted start or reset.
- start is ignored in DRIVE and DONE. There is no queuing.
- Outputs are sampled only on the final hold edge, so glitches or mismatches earlier in the hold window are not counted.
- mismatch_cnt is N_IN+1 bits wide and saturates naturally at 2^N_IN. It cannot wrap.
- stim wrap from all-ones to 0 never occurs inside DRIVE; the run ends instead.

## Timing
- All outputs are registered, and all state changes happen on the rising clk edge.
- Let start be accepted at edge k:
  - stim=0 and busy=1 from edge k.
  - Vector v is driven from edge k+v·HOLD_CYCLES.
  - Vector v is sampled at edge k+(v+1)·HOLD_CYCLES.
- done=1 and pass are valid from edge k+2^N_IN·HOLD_CYCLES, for exactly one cycle. With the defaults this is 40 cycles.
- IDLE is re-entered one cycle later. If start is held high, the earliest next acceptance comes one cycle after that, so the repeat period is 2^N_IN·HOLD_CYCLES+2 cycles.
- The gate instances are combinational, so y_* must be settled within the hold window. HOLD_CYCLES=1 samples at the end of the same cycle in which the vector is driven.

## Test plan
- Both inputs driven by an identical AND model, defaults, start pulsed at cycle 0:
  - stim steps 0,1,2,3 every 10 cycles.
  - done pulses at edge 40.
  - mismatch_cnt=0, pass=1, first_fail_valid=0.
- y_wire=AND and y_reg stuck at 1: mismatch_cnt=3, first_fail_vec=0, first_fail_valid=1, pass=0 at done.
- y_reg inverted only for stim=2: mismatch_cnt=1 and first_fail_vec=2.
  - Also pulse y_reg wrong for cycles 3–5 of vector 1 only; this is not counted.
- Extra start pulse at cycle 15 during DRIVE:
  - It is ignored.
  - Exactly one done, at edge 40, and stim is not restarted.
- rst_n low at cycle 25 mid-run: all outputs read 0 immediately, before the next clk edge. A subsequent start runs a full clean 40-cycle sequence.
- HOLD_CYCLES=1 with start held high continuously:
  - done pulses at edge 4.
  - Runs repeat every 6 cycles.
  - Results are cleared at each new acceptance.
